// File: rtl/decoder_5_to_32_reg_if.sv
// Handshake bus for decoder_5_to_32_reg: code input side and one-hot result output side.
interface decoder_5_to_32_reg_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_code;
    logic        in_en;
    logic [31:0] dec_output;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dec_count;

    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, dec_output, out_valid, dec_count
    );

    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, dec_output, out_valid, dec_count
    );
endinterface

// File: rtl/decoder_5_to_32_reg.sv
// Registered 5-to-32 one-hot decoder behind a one-entry valid/ready output stage.
// Define DEC_COUNT_EN to add a saturating 16-bit count of accepted codes.
module decoder_5_to_32_reg (
    input  logic                        clk,
    input  logic                        clr,
    decoder_5_to_32_reg_if.slave        bus
);
    localparam int unsigned OUT_W = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_dec;
    logic               w_in_ready;
    logic               w_accept;
    logic [OUT_W-1:0]   w_word;

    // A full slot can take a new code in the same cycle it is being drained.
    assign w_in_ready = (r_state == ST_EMPTY) || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_word     = bus.in_en ? (OUT_W'(1) << bus.in_code) : '0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_EMPTY;
            r_dec   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                        r_dec   <= w_word;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_dec <= w_word;
                    end else if (bus.out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == ST_FULL);
    assign bus.dec_output = r_dec;

`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] r_count;

    // Saturates rather than wraps; disabled (in_en=0) accepts still count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.dec_count = r_count;
`else
    assign bus.dec_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_decoder_5_to_32_reg.sv
// Directed self-checking bench for decoder_5_to_32_reg (both DEC_COUNT_EN builds).
module tb_decoder_5_to_32_reg;
    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    decoder_5_to_32_reg_if u_if ();

    decoder_5_to_32_reg u_dut (
        .clk (clk),
        .clr (clr),
        .bus (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        #1 clr = 1'b1;
        #1 clr = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_word;
        n_checks = 0;
        n_pass   = 0;
        clr                = 1'b1;
        u_if.in_valid      = 1'b0;
        u_if.in_code       = 5'd0;
        u_if.in_en         = 1'b1;
        u_if.out_ready     = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(u_if.out_valid), 32'h0);
        check("rst_dec_output", u_if.dec_output, 32'h0);
        check("rst_dec_count", 32'(u_if.dec_count), 32'h0);
        check("rst_in_ready", 32'(u_if.in_ready), 32'h1);
        clr = 1'b0;

        // Single code 0, one-cycle latency, then drains
        u_if.in_code  = 5'd0;
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        check("c0_out_valid", 32'(u_if.out_valid), 32'h1);
        check("c0_dec_output", u_if.dec_output, 32'h00000001);
        tick();
        check("c0_drained", 32'(u_if.out_valid), 32'h0);
        check("c0_hold_word", u_if.dec_output, 32'h00000001);

        // Back-to-back sweep of all codes from a fresh reset
        pulse_clr();
        for (int k = 0; k < 32; k++) begin
            u_if.in_code  = 5'(k);
            u_if.in_valid = 1'b1;
            tick();
            exp_word = 32'h1 << k;
            check($sformatf("sweep_valid_%0d", k), 32'(u_if.out_valid), 32'h1);
            check($sformatf("sweep_word_%0d", k), u_if.dec_output, exp_word);
        end
        u_if.in_valid = 1'b0;
`ifdef DEC_COUNT_EN
        check("sweep_count", 32'(u_if.dec_count), 32'd32);
`else
        check("sweep_count", 32'(u_if.dec_count), 32'd0);
`endif
        tick();
        check("sweep_drained", 32'(u_if.out_valid), 32'h0);

        // Backpressure: hold 31 while code 7 waits
        u_if.in_code  = 5'd31;
        u_if.in_valid = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        u_if.in_code   = 5'd7;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_word_%0d", k), u_if.dec_output, 32'h80000000);
            check($sformatf("bp_valid_%0d", k), 32'(u_if.out_valid), 32'h1);
            check($sformatf("bp_in_ready_%0d", k), 32'(u_if.in_ready), 32'h0);
            tick();
        end
        u_if.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(u_if.in_ready), 32'h1);
        tick();
        u_if.in_valid = 1'b0;
        check("bp_new_word", u_if.dec_output, 32'h00000080);
        check("bp_new_valid", 32'(u_if.out_valid), 32'h1);
        tick();
        check("bp_drained", 32'(u_if.out_valid), 32'h0);

        // Disabled decode emits a zero word
        u_if.in_en    = 1'b0;
        u_if.in_code  = 5'd12;
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        u_if.in_en    = 1'b1;
        check("en0_word", u_if.dec_output, 32'h0);
        check("en0_valid", 32'(u_if.out_valid), 32'h1);
        tick();

        // Asynchronous clear while a word is held
        u_if.in_code  = 5'd4;
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        check("pre_clr_word", u_if.dec_output, 32'h00000010);
        #2 clr = 1'b1;
        #1;
        check("async_clr_valid", 32'(u_if.out_valid), 32'h0);
        check("async_clr_word", u_if.dec_output, 32'h0);
        check("async_clr_count", 32'(u_if.dec_count), 32'h0);
        check("async_clr_ready", 32'(u_if.in_ready), 32'h1);
        #1 clr = 1'b0;

        // First edge after clear accepts
        u_if.in_code   = 5'd9;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        check("post_clr_word", u_if.dec_output, 32'h00000200);
        check("post_clr_valid", 32'(u_if.out_valid), 32'h1);
        tick();

`ifdef DEC_COUNT_EN
        // Counter saturation
        pulse_clr();
        u_if.in_valid = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            tick();
        end
        check("cnt_at_max", 32'(u_if.dec_count), 32'h0000FFFF);
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        u_if.in_valid = 1'b0;
        check("cnt_saturated", 32'(u_if.dec_count), 32'h0000FFFF);
`else
        u_if.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        u_if.in_valid = 1'b0;
        check("cnt_tied_zero", 32'(u_if.dec_count), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decoder_5_to_32_reg.md
DECODER_5_TO_32_REG -- requirements
Module: decoder_5_to_32_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately when clr rises, independent of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  producer presents a code this cycle.
REQ-005 in_ready  output  1  block accepts a code this cycle.
REQ-006 in_code  input  5  binary register index, 0-31.
REQ-007 in_en  input  1  1 = decode in_code; 0 = emit all-zero word (no register selected).
REQ-008 dec_output  output  32  registered one-hot (or zero) select word.
REQ-009 out_valid  output  1  dec_output holds an undelivered result.
REQ-010 out_ready  input  1  consumer takes dec_output this cycle.
REQ-011 dec_count  output  16  number of accepted codes (see Configuration).

Function
REQ-012 The block SHALL be a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-014 Accept SHALL occur on a rising clk edge with in_valid && in_ready: dec_output <= (in_en ? 32'h1 << in_code : 32'h0), out_valid <= 1.
REQ-015 Latency SHALL be exactly one cycle from the accept edge to out_valid=1 with the new word.
REQ-016 Pop SHALL occur on a rising clk edge with out_valid && out_ready.
REQ-017 EMPTY->FULL on accept; FULL->EMPTY on pop without accept; FULL->FULL on simultaneous pop and accept, with dec_output replaced by the new word and no bubble.
REQ-018 While FULL and out_ready=0, dec_output and out_valid SHALL hold stable, and in_ready SHALL be 0.
REQ-019 in_valid while in_ready=0 SHALL be ignored; the producer holds its code.
REQ-020 When EMPTY, dec_output SHALL keep its last value; consumers qualify it with out_valid.
REQ-021 With in_en=1, dec_output SHALL have exactly one bit set, at position in_code; with in_en=0 it SHALL be 32'h0.
REQ-022 Every in_code value 0-31 is legal; no code SHALL produce X or a multi-hot output.

Reset
REQ-023 When clr is asserted: out_valid=0, dec_output=32'h0, dec_count=16'h0, state=EMPTY.
REQ-024 in_ready SHALL read 1 during and after reset, following REQ-013.
REQ-025 A reset mid-transfer SHALL discard the held word; no pop is reported for it.
REQ-026 The first accept SHALL be possible on the first rising clk edge after clr deasserts.

Configuration
REQ-027 Macro DEC_COUNT_EN: when defined, dec_count SHALL increment by 1 on every accept, saturating at 16'hFFFF and never wrapping; accepts with in_en=0 also count.
REQ-028 When DEC_COUNT_EN is undefined, no counter logic SHALL exist and dec_count SHALL be tied to 16'h0; all other behaviour is unchanged.

Verification
REQ-029 Reset, then in_code=5'd0, in_en=1, in_valid=1 for 1 cycle, out_ready=1 -> next cycle dec_output=32'h00000001 and out_valid=1; the following cycle out_valid=0.
REQ-030 Sweep in_code 0..31 back-to-back with out_ready=1 -> 32 consecutive valid cycles with dec_output=32'h1<<k, no bubbles; dec_count=32 when DEC_COUNT_EN is defined.
REQ-031 Accept 5'd31, hold out_ready=0 for 5 cycles while in_valid=1 with code 5'd7 -> dec_output stays 32'h80000000 and in_ready=0; on out_ready=1, the next cycle shows 32'h00000080.
REQ-032 in_en=0 with in_code=5'd12 -> dec_output=32'h00000000, out_valid=1.
REQ-033 Accept 5'd4, then assert clr asynchronously mid-cycle while out_ready=0 -> out_valid=0 and dec_output=32'h0 immediately, before the next clk edge.
REQ-034 With DEC_COUNT_EN defined, force 65540 accepts -> dec_count=16'hFFFF; without the macro -> dec_count=16'h0 throughout.
